// File: rtl/udp_img_depkt_if.sv
// udp_img_depkt_if: receive-payload in, pixel-write stream out.
// master = payload source / pixel sink, slave = depacketizer.
interface udp_img_depkt_if;
  logic        rec_en;
  logic [31:0] rec_data;
  logic        rec_pkt_done;
  logic [15:0] rec_byte_num;
  logic        img_frame_start;
  logic        img_wr_en;
  logic [31:0] img_wr_data;
  logic [15:0] img_x;
  logic [15:0] img_y;
  logic [15:0] img_width;
  logic [15:0] img_height;
  logic        img_frame_done;
  logic        pkt_err;
  logic [15:0] frame_cnt;

  modport master (
    output rec_en, rec_data, rec_pkt_done, rec_byte_num,
    input  img_frame_start, img_wr_en, img_wr_data,
    input  img_x, img_y, img_width, img_height,
    input  img_frame_done, pkt_err, frame_cnt
  );

  modport slave (
    input  rec_en, rec_data, rec_pkt_done, rec_byte_num,
    output img_frame_start, img_wr_en, img_wr_data,
    output img_x, img_y, img_width, img_height,
    output img_frame_done, pkt_err, frame_cnt
  );
endinterface

// File: rtl/udp_img_depkt.sv
// udp_img_depkt: reassembles video frames from 32-bit UDP payload words.
// Ports: eth_rx_clk, rst (sync, high), bus (slave: rec_* in, img_* out).
module udp_img_depkt #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter logic [15:0] MAX_W     = 16'd1920,
  parameter logic [15:0] MAX_H     = 16'd1080
) (
  input logic            eth_rx_clk,
  input logic            rst,
  udp_img_depkt_if.slave bus
);

  typedef enum logic [1:0] {HDR, SIZE, PIX, DROP} st_t;

  st_t         st, st_w, st_n;
  logic        act, act_n;
  logic [6:0]  seq_q, seq_n;
  logic [15:0] x, x_n, y, y_n;
  logic [15:0] w_q, w_n, h_q, h_n;
  logic [15:0] cnt_q, cnt_n;
  logic [15:0] ix_q, ix_n, iy_q, iy_n;
  logic [31:0] wd_q, wd_n;
  logic        wr_q, wr_n;
  logic        start_q, start_n;
  logic        done_q, done_n;
  logic        err_q, err_n;

  logic [31:0] d;
  logic        sync_ok, sof, seq_ok;
  logic [6:0]  seq;
  logic [15:0] sw, sh;
  logic        size_ok, x_end, last;
  logic        unused_bn;

  assign d       = bus.rec_data;
  assign sync_ok = d[31:24] == SYNC_BYTE;
  assign sof     = d[23];
  assign seq     = d[22:16];
  assign seq_ok  = seq == seq_q;
  assign sw      = d[31:16];
  assign sh      = d[15:0];
  assign size_ok = (sw != 16'd0) && (sh != 16'd0)
                && (sw <= MAX_W) && (sh <= MAX_H);
  assign x_end   = x == (w_q - 16'd1);
  assign last    = x_end && (y == (h_q - 16'd1));
  assign unused_bn = ^bus.rec_byte_num[15:2];

  always_ff @(posedge eth_rx_clk) begin
    if (rst) st <= HDR;
    else     st <= st_n;
  end

  // st_w is the state after the word of this cycle; packet end
  // is judged against it so a same-cycle word is handled first.
  always_comb begin
    st_w = st;
    if (bus.rec_en) begin
      unique case (st)
        HDR: begin
          if (!sync_ok)           st_w = DROP;
          else if (sof)           st_w = SIZE;
          else if (act && seq_ok) st_w = PIX;
          else                    st_w = DROP;
        end
        SIZE:    st_w = size_ok ? PIX : DROP;
        PIX:     if (last) st_w = DROP;
        default: st_w = st;
      endcase
    end
    st_n = bus.rec_pkt_done ? HDR : st_w;
  end

  always_comb begin
    act_n   = act;
    seq_n   = seq_q;
    x_n     = x;
    y_n     = y;
    w_n     = w_q;
    h_n     = h_q;
    cnt_n   = cnt_q;
    ix_n    = ix_q;
    iy_n    = iy_q;
    wd_n    = wd_q;
    wr_n    = 1'b0;
    start_n = 1'b0;
    done_n  = 1'b0;
    err_n   = 1'b0;
    if (bus.rec_en) begin
      unique case (st)
        HDR: begin
          if (!sync_ok) begin
            err_n = 1'b1;
            act_n = 1'b0;
          end else if (sof) begin
            err_n = act;
            act_n = 1'b0;
            seq_n = seq + 7'd1;
          end else if (act && seq_ok) begin
            seq_n = seq_q + 7'd1;
          end else begin
            err_n = act;
            act_n = 1'b0;
          end
        end
        SIZE: begin
          if (!size_ok) begin
            err_n = 1'b1;
          end else begin
            w_n     = sw;
            h_n     = sh;
            x_n     = 16'd0;
            y_n     = 16'd0;
            act_n   = 1'b1;
            start_n = 1'b1;
          end
        end
        PIX: begin
          wr_n = 1'b1;
          wd_n = d;
          ix_n = x;
          iy_n = y;
          if (x_end) begin
            x_n = 16'd0;
            y_n = y + 16'd1;
          end else begin
            x_n = x + 16'd1;
          end
          if (last) begin
            done_n = 1'b1;
            cnt_n  = cnt_q + 16'd1;
            act_n  = 1'b0;
          end
        end
        default: ;
      endcase
    end
    if (bus.rec_pkt_done) begin
      if (st_w == SIZE) begin
        err_n = 1'b1;
        act_n = 1'b0;
      end
      if (bus.rec_byte_num[1:0] != 2'd0) begin
        err_n = 1'b1;
        act_n = 1'b0;
      end
    end
  end

  always_ff @(posedge eth_rx_clk) begin
    if (rst) begin
      act     <= 1'b0;
      seq_q   <= 7'd0;
      x       <= 16'd0;
      y       <= 16'd0;
      w_q     <= 16'd0;
      h_q     <= 16'd0;
      cnt_q   <= 16'd0;
      ix_q    <= 16'd0;
      iy_q    <= 16'd0;
      wd_q    <= 32'd0;
      wr_q    <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      act     <= act_n;
      seq_q   <= seq_n;
      x       <= x_n;
      y       <= y_n;
      w_q     <= w_n;
      h_q     <= h_n;
      cnt_q   <= cnt_n;
      ix_q    <= ix_n;
      iy_q    <= iy_n;
      wd_q    <= wd_n;
      wr_q    <= wr_n;
      start_q <= start_n;
      done_q  <= done_n;
      err_q   <= err_n;
    end
  end

  assign bus.img_frame_start = start_q;
  assign bus.img_wr_en       = wr_q;
  assign bus.img_wr_data     = wd_q;
  assign bus.img_x           = ix_q;
  assign bus.img_y           = iy_q;
  assign bus.img_width       = w_q;
  assign bus.img_height      = h_q;
  assign bus.img_frame_done  = done_q;
  assign bus.pkt_err         = err_q;
  assign bus.frame_cnt       = cnt_q;

endmodule

// File: tb/tb_udp_img_depkt.sv
// tb_udp_img_depkt: per-cycle vector table for udp_img_depkt.
// Ports: none; drives the interface master side and checks outputs.
module tb_udp_img_depkt;

  logic clk;
  logic rst;
  udp_img_depkt_if bus ();

  udp_img_depkt dut (
    .eth_rx_clk (clk),
    .rst        (rst),
    .bus        (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst;
    logic        en;
    logic [31:0] d;
    logic        dn;
    logic [15:0] bn;
    logic        st;
    logic        wr;
    logic [31:0] wd;
    logic [15:0] x;
    logic [15:0] y;
    logic        fd;
    logic        er;
    logic [15:0] cnt;
    logic [15:0] w;
    logic [15:0] h;
  } vec_t;

  vec_t tv[$];
  int checks   = 0;
  int failures = 0;
  bit done     = 1'b0;

  function automatic vec_t blank();
    vec_t t;
    t.rst = 1'b0; t.en = 1'b0; t.d = 32'd0;
    t.dn = 1'b0; t.bn = 16'd0; t.st = 1'b0;
    t.wr = 1'b0; t.wd = 32'd0; t.x = 16'd0;
    t.y = 16'd0; t.fd = 1'b0; t.er = 1'b0;
    t.cnt = 16'd0; t.w = 16'd0; t.h = 16'd0;
    return t;
  endfunction

  task automatic v(input logic en, input logic [31:0] d,
                   input logic dn, input logic [15:0] bn,
                   input logic st, input logic er,
                   input logic [15:0] cnt,
                   input logic [15:0] w, input logic [15:0] h);
    vec_t t;
    t = blank();
    t.en = en; t.d = d; t.dn = dn; t.bn = bn;
    t.st = st; t.er = er; t.cnt = cnt; t.w = w; t.h = h;
    tv.push_back(t);
  endtask

  task automatic vr();
    vec_t t;
    t = blank();
    t.rst = 1'b1;
    tv.push_back(t);
  endtask

  task automatic px(input logic [31:0] base, input int n,
                    input int x0, input int y0,
                    input int wdt, input int hgt,
                    input bit lst, input logic [15:0] cnt);
    for (int k = 0; k < n; k++) begin
      vec_t t;
      int p;
      p = y0 * wdt + x0 + k;
      t = blank();
      t.en = 1'b1;
      t.d = base + 32'(k);
      t.wr = 1'b1;
      t.wd = base + 32'(k);
      t.x = 16'(p % wdt);
      t.y = 16'(p / wdt);
      t.fd = lst && (k == n - 1);
      t.cnt = cnt + (t.fd ? 16'd1 : 16'd0);
      t.w = 16'(wdt);
      t.h = 16'(hgt);
      tv.push_back(t);
    end
  endtask

  task automatic dw(input int n, input logic [15:0] cnt,
                    input logic [15:0] w, input logic [15:0] h);
    for (int k = 0; k < n; k++)
      v(1'b1, 32'hDEAD_0000 + 32'(k), 1'b0, 16'd0,
        1'b0, 1'b0, cnt, w, h);
  endtask

  localparam logic [31:0] SOF0 = 32'hA580_0000;

  initial begin
    #200000;
    if (!done) begin
      failures++;
      $display("FAIL timeout: vector run did not finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    rst = 1'b1;
    bus.rec_en = 1'b0;
    bus.rec_data = 32'd0;
    bus.rec_pkt_done = 1'b0;
    bus.rec_byte_num = 16'd0;

    @(posedge clk);
    #1;
    checks++;
    if (bus.img_frame_start !== 1'b0 || bus.img_wr_en !== 1'b0
        || bus.img_wr_data !== 32'd0 || bus.img_x !== 16'd0
        || bus.img_y !== 16'd0 || bus.img_width !== 16'd0
        || bus.img_height !== 16'd0 || bus.img_frame_done !== 1'b0
        || bus.pkt_err !== 1'b0 || bus.frame_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset state: st=%b wr=%b d=%h x=%0d y=%0d w=%0d h=%0d fd=%b er=%b cnt=%0d",
        bus.img_frame_start, bus.img_wr_en, bus.img_wr_data,
        bus.img_x, bus.img_y, bus.img_width, bus.img_height,
        bus.img_frame_done, bus.pkt_err, bus.frame_cnt);
    end

    vr();
    v(1, SOF0, 0, 0, 0, 0, 0, 0, 0);
    v(1, 32'h0004_0002, 0, 0, 1, 0, 0, 4, 2);
    px(32'd1, 8, 0, 0, 4, 2, 1, 0);
    v(0, 0, 1, 40, 0, 0, 1, 4, 2);
    v(1, SOF0, 0, 0, 0, 0, 1, 4, 2);
    v(1, 32'h0004_0002, 0, 0, 1, 0, 1, 4, 2);
    px(32'd11, 4, 0, 0, 4, 2, 0, 1);
    v(0, 0, 1, 24, 0, 0, 1, 4, 2);
    v(1, 32'hA501_0000, 0, 0, 0, 0, 1, 4, 2);
    px(32'd15, 4, 0, 1, 4, 2, 1, 1);
    v(0, 0, 1, 20, 0, 0, 2, 4, 2);
    v(1, SOF0, 0, 0, 0, 0, 2, 4, 2);
    v(1, 32'h0004_0002, 0, 0, 1, 0, 2, 4, 2);
    px(32'd21, 4, 0, 0, 4, 2, 0, 2);
    v(0, 0, 1, 24, 0, 0, 2, 4, 2);
    v(1, 32'hA503_0000, 0, 0, 0, 1, 2, 4, 2);
    dw(4, 2, 4, 2);
    v(0, 0, 1, 20, 0, 0, 2, 4, 2);
    v(1, SOF0, 0, 0, 0, 0, 2, 4, 2);
    v(1, 32'h0002_0001, 0, 0, 1, 0, 2, 2, 1);
    px(32'd31, 2, 0, 0, 2, 1, 1, 2);
    v(0, 0, 1, 16, 0, 0, 3, 2, 1);
    v(1, SOF0, 0, 0, 0, 0, 3, 2, 1);
    v(1, 32'h0781_0010, 0, 0, 0, 1, 3, 2, 1);
    dw(2, 3, 2, 1);
    v(0, 0, 1, 16, 0, 0, 3, 2, 1);
    v(1, SOF0, 0, 0, 0, 0, 3, 2, 1);
    v(1, 32'h0780_0438, 0, 0, 1, 0, 3, 1920, 1080);
    px(32'd41, 1, 0, 0, 1920, 1080, 0, 3);
    v(0, 0, 1, 12, 0, 0, 3, 1920, 1080);
    v(1, SOF0, 0, 0, 0, 1, 3, 1920, 1080);
    v(1, 32'h0004_0002, 0, 0, 1, 0, 3, 4, 2);
    px(32'd51, 3, 0, 0, 4, 2, 0, 3);
    v(0, 0, 1, 20, 0, 0, 3, 4, 2);
    v(1, SOF0, 0, 0, 0, 1, 3, 4, 2);
    v(1, 32'h0004_0002, 0, 0, 1, 0, 3, 4, 2);
    px(32'd61, 8, 0, 0, 4, 2, 1, 3);
    v(0, 0, 1, 40, 0, 0, 4, 4, 2);
    v(1, SOF0, 0, 0, 0, 0, 4, 4, 2);
    v(1, 32'h0004_0000, 0, 0, 0, 1, 4, 4, 2);
    v(0, 0, 1, 8, 0, 0, 4, 4, 2);
    v(1, SOF0, 0, 0, 0, 0, 4, 4, 2);
    v(1, 32'h0000_0002, 0, 0, 0, 1, 4, 4, 2);
    v(0, 0, 1, 8, 0, 0, 4, 4, 2);
    v(1, SOF0, 0, 0, 0, 0, 4, 4, 2);
    v(1, 32'h0002_0001, 0, 0, 1, 0, 4, 2, 1);
    px(32'd71, 1, 0, 0, 2, 1, 0, 4);
    v(0, 0, 1, 13, 0, 1, 4, 2, 1);
    v(1, 32'hA501_0000, 0, 0, 0, 0, 4, 2, 1);
    dw(1, 4, 2, 1);
    v(0, 0, 1, 8, 0, 0, 4, 2, 1);
    v(1, SOF0, 1, 4, 0, 1, 4, 2, 1);
    v(0, 0, 1, 0, 0, 0, 4, 2, 1);
    v(1, 32'h5A80_0000, 0, 0, 0, 1, 4, 2, 1);
    v(0, 0, 1, 4, 0, 0, 4, 2, 1);
    v(1, 32'hA5FF_0000, 0, 0, 0, 0, 4, 2, 1);
    v(1, 32'h0002_0002, 0, 0, 1, 0, 4, 2, 2);
    px(32'd81, 2, 0, 0, 2, 2, 0, 4);
    v(0, 0, 1, 16, 0, 0, 4, 2, 2);
    v(1, 32'hA500_0000, 0, 0, 0, 0, 4, 2, 2);
    px(32'd83, 2, 0, 1, 2, 2, 1, 4);
    v(0, 0, 1, 12, 0, 0, 5, 2, 2);
    v(1, SOF0, 0, 0, 0, 0, 5, 2, 2);
    v(1, 32'h0004_0002, 0, 0, 1, 0, 5, 4, 2);
    px(32'd91, 5, 0, 0, 4, 2, 0, 5);
    vr();
    v(1, SOF0, 0, 0, 0, 0, 0, 0, 0);
    v(1, 32'h0002_0001, 0, 0, 1, 0, 0, 2, 1);
    px(32'd101, 2, 0, 0, 2, 1, 1, 0);
    v(0, 0, 1, 16, 0, 0, 1, 2, 1);

    for (int i = 0; i < tv.size(); i++) begin
      vec_t e;
      bit ok;
      e = tv[i];
      rst = e.rst;
      bus.rec_en = e.en;
      bus.rec_data = e.d;
      bus.rec_pkt_done = e.dn;
      bus.rec_byte_num = e.bn;
      @(posedge clk);
      #1;
      checks++;
      ok = (bus.img_frame_start === e.st)
        && (bus.img_wr_en === e.wr)
        && (bus.img_frame_done === e.fd)
        && (bus.pkt_err === e.er)
        && (bus.frame_cnt === e.cnt)
        && (bus.img_width === e.w)
        && (bus.img_height === e.h);
      if (e.wr || e.rst)
        ok = ok && (bus.img_wr_data === e.wd)
                && (bus.img_x === e.x)
                && (bus.img_y === e.y);
      if (!ok) begin
        failures++;
        $display("FAIL vec%0d got st=%b wr=%b d=%h x=%0d y=%0d fd=%b er=%b cnt=%0d w=%0d h=%0d want st=%b wr=%b d=%h x=%0d y=%0d fd=%b er=%b cnt=%0d w=%0d h=%0d",
          i, bus.img_frame_start, bus.img_wr_en, bus.img_wr_data,
          bus.img_x, bus.img_y, bus.img_frame_done, bus.pkt_err,
          bus.frame_cnt, bus.img_width, bus.img_height,
          e.st, e.wr, e.wd, e.x, e.y, e.fd, e.er, e.cnt, e.w, e.h);
      end
    end

    done = 1'b1;
    rst = 1'b0;
    bus.rec_en = 1'b0;
    bus.rec_pkt_done = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/udp_img_depkt.md
Name: udp_img_depkt

Overview:
Receive-side counterpart of the image packetizer. Takes the 32-bit UDP payload stream from the eth_top receive path (rec_en/rec_data/rec_pkt_done/rec_byte_num, gmii_rx_clk domain) and reassembles video frames. It emits a pixel write stream with x/y coordinates, frame start/done strobes and an error strobe, ready for a frame-buffer writer. Packet format: word0 = packet header, SOF packets add a size word, all remaining words are pixels.

Parameters:
SYNC_BYTE, 8'hA5, required value of header bits [31:24]
MAX_W, 16'd1920, largest accepted frame width in pixels
MAX_H, 16'd1080, largest accepted frame height in lines

Ports:
eth_rx_clk  in  1  receive clock; sole clock
rst  in  1  synchronous reset, active-high
rec_en  in  1  rec_data valid, one 32-bit word per strobe
rec_data  in  32  payload word, first byte received in [31:24]
rec_pkt_done  in  1  1-cycle pulse, end of UDP packet
rec_byte_num  in  16  payload byte count, valid with rec_pkt_done
img_frame_start  out  1  1-cycle pulse, valid size word accepted
img_wr_en  out  1  pixel valid
img_wr_data  out  32  pixel
img_x  out  16  column of current pixel
img_y  out  16  row of current pixel
img_width  out  16  width of current frame
img_height  out  16  height of current frame
img_frame_done  out  1  1-cycle pulse, coincident with last pixel of frame
pkt_err  out  1  1-cycle pulse, protocol error or frame abandoned
frame_cnt  out  16  completed frames, wraps at 65535->0

Behaviour:
- Reset: all outputs 0; state HDR; frame_active=0; seq_exp=0.
- Header word: [31:24] sync, [23] sof, [22:16] seq (7-bit), [15:0] ignored. Size word: [31:16] width, [15:0] height.
- All outputs registered. Latency is 1 cycle from the rec_en word to img_wr_en, img_frame_start and img_frame_done.
- HDR, on rec_en:
  - If sync != SYNC_BYTE: pkt_err; frame_active=0; go to DROP.
  - If sof=1: pkt_err if frame_active (truncated frame); frame_active=0; seq_exp=seq+1; go to SIZE.
  - If sof=0, frame_active=1 and seq==seq_exp: seq_exp+=1; go to PIX.
  - If sof=0 otherwise: pkt_err only if frame_active; frame_active=0; go to DROP.
- SIZE, on rec_en:
  - If width or height is 0, width>MAX_W or height>MAX_H: pkt_err; go to DROP.
  - Otherwise: latch img_width and img_height; x=y=0; frame_active=1; img_frame_start; go to PIX.
- PIX, on rec_en:
  - img_wr_en=1; img_wr_data=word; img_x/img_y = current x/y.
  - Then x+=1. At x==width-1: x=0, y+=1.
  - Last pixel (x==width-1 and y==height-1): img_frame_done in the same cycle as its img_wr_en; frame_cnt+=1; frame_active=0; go to DROP. Surplus words are ignored silently.
- DROP: ignores all words.
- rec_pkt_done, from any state: next state is HDR. If rec_en is in the same cycle, that word is processed first.
  - In HDR with zero words received (empty packet): no error.
  - In SIZE (size word missing): pkt_err; frame_active=0.
  - In PIX with frame incomplete: frame_active stays 1; x/y are kept; the frame continues in the next packet.
- rec_pkt_done with rec_byte_num[1:0]!=0: pkt_err, and the frame is abandoned (frame_active=0).
- Multiple error causes in one cycle give a single pkt_err pulse.
- seq arithmetic is modulo 128: seq 127 is followed by 0.
- img_width and img_height hold their values until the next accepted size word.
- rst asserted mid-frame: everything returns to reset values on the next edge, with no done or err pulse.

Test Plan:
- Header A5800000, size 00040002, 8 pixel words 1..8, done with byte_num=40 -> frame_start; 8 img_wr_en with x/y (0,0)..(3,1); frame_done with pixel 8; frame_cnt=1; no pkt_err.
- 4x2 frame split: packet 1 = A5800000, size, 4 pixels; packet 2 = A5010000, 4 pixels -> 8 contiguous writes; y=1 begins in packet 2; a single frame_done.
- Split frame with packet 2 header A5030000 (seq gap) -> pkt_err once; packet 2 pixels not written; no frame_done; next SOF packet recovers normally.
- Size word 07810010 (width 1921) -> pkt_err; no frame_start; no img_wr_en for the rest of the packet.
- SOF packet arriving mid-frame after 3 of 8 pixels -> pkt_err; new frame_start; x/y restart at 0; frame_cnt unchanged until the new frame completes.
- rst pulsed after 5 pixels -> all outputs 0 next cycle; following frame decodes with frame_cnt=1.
